// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: shadow register, static HEX buses, multiplexed scan bus, per-digit blink.
// Optional leading-zero blanking is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dots,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [8*NUM_DIGITS-1:0]   hex_out,
  output logic [7:0]                scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0]       shadowValue_q;
  logic [NUM_DIGITS-1:0]         shadowDots_q;
  logic [SCAN_W-1:0]             scanCnt_q,   scanCnt_d;
  logic [IDX_W-1:0]              scanIdx_q,   scanIdx_d;
  logic [BLINK_W-1:0]            blinkCnt_q,  blinkCnt_d;
  logic                          blinkPhase_q, blinkPhase_d;
  logic [8*NUM_DIGITS-1:0]       hexOut_q;
  logic [7:0]                    scanSeg_q,   scanSeg_d;
  logic [NUM_DIGITS-1:0]         scanAn_q,    scanAn_d;
  logic [NUM_DIGITS-1:0][7:0]    digitByte;

  function automatic logic [6:0] decodeNibble(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Walk from the most significant digit so the leading-zero run can end at the first significant digit.
  always_comb begin
    logic [3:0] nib;
`ifdef SEG7_LZ_BLANK_EN
    logic lzRun;
    lzRun = 1'b1;
`endif
    nib       = '0;
    digitByte = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib          = shadowValue_q[4*i +: 4];
      digitByte[i] = {~shadowDots_q[i], decodeNibble(nib)};
`ifdef SEG7_LZ_BLANK_EN
      if (i != 0 && lzRun && nib == 4'h0 && !shadowDots_q[i])
        digitByte[i] = 8'hFF;
      else
        lzRun = 1'b0;
`endif
      if (blink_mask[i] && !blinkPhase_q)
        digitByte[i] = 8'hFF;
    end
  end

  always_comb begin
    scanCnt_d    = (scanCnt_q == SCAN_MAX) ? '0 : scanCnt_q + 1'b1;
    scanIdx_d    = scanIdx_q;
    if (scanCnt_q == SCAN_MAX)
      scanIdx_d = (scanIdx_q == IDX_MAX) ? '0 : scanIdx_q + 1'b1;
    blinkCnt_d   = (blinkCnt_q == BLINK_MAX) ? '0 : blinkCnt_q + 1'b1;
    blinkPhase_d = (blinkCnt_q == BLINK_MAX) ? ~blinkPhase_q : blinkPhase_q;
    scanSeg_d    = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (scanIdx_q == IDX_W'(i))
        scanSeg_d = digitByte[i];
    scanAn_d     = ~(NUM_DIGITS'(1) << scanIdx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadowValue_q <= '0;
      shadowDots_q  <= '0;
      scanCnt_q     <= '0;
      scanIdx_q     <= '0;
      blinkCnt_q    <= '0;
      blinkPhase_q  <= 1'b1;
      hexOut_q      <= '1;
      scanSeg_q     <= 8'hFF;
      scanAn_q      <= '1;
    end else begin
      if (load) begin
        shadowValue_q <= value;
        shadowDots_q  <= dots;
      end
      scanCnt_q    <= scanCnt_d;
      scanIdx_q    <= scanIdx_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      hexOut_q     <= digitByte;
      scanSeg_q    <= scanSeg_d;
      scanAn_q     <= scanAn_d;
    end
  end

  assign hex_out  = hexOut_q;
  assign scan_seg = scanSeg_q;
  assign scan_an  = scanAn_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (4 digits, short scan and blink periods).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dots;
  logic [3:0]  blink_mask;
  logic [31:0] hex_out;
  logic [7:0]  scan_seg;
  logic [3:0]  scan_an;

  int checks = 0;
  int errors = 0;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [31:0] ZERO_HEX = 32'hFFFFFFC0;
  localparam logic [31:0] LZ_HEX   = 32'hFFFF92C0;
`else
  localparam logic [31:0] ZERO_HEX = 32'hC0C0C0C0;
  localparam logic [31:0] LZ_HEX   = 32'hC0C092C0;
`endif

  seg7_display_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .BLINK_DIV (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .dots      (dots),
    .blink_mask(blink_mask),
    .hex_out   (hex_out),
    .scan_seg  (scan_seg),
    .scan_an   (scan_an)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rstN, input logic ld, input logic [15:0] val,
                               input logic [3:0] dts, input logic [3:0] mask, input int n);
    rst_n      = rstN;
    load       = ld;
    value      = val;
    dots       = dts;
    blink_mask = mask;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held for three cycles
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 3);
    checkOutput("rst_hex",  hex_out,         32'hFFFFFFFF);
    checkOutput("rst_seg",  {24'h0, scan_seg}, 32'h000000FF);
    checkOutput("rst_an",   {28'h0, scan_an},  32'h0000000F);

    // First edge after release shows the zero shadow
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1);
    checkOutput("rel_hex",  hex_out,         ZERO_HEX);
    checkOutput("rel_an",   {28'h0, scan_an},  32'h0000000E);

    // One-cycle load, then source changes without load
    applyStimulus(1'b1, 1'b1, 16'h1A3F, 4'b0100, 4'b0000, 1);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'b1111, 4'b0000, 1);
    checkOutput("load_hex", hex_out,         32'hF908B08E);
    tick(3);
    checkOutput("hold_hex", hex_out,         32'hF908B08E);

    // Leading zeros, without and with a dot on the top digit
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'b0000, 4'b0000, 1);
    applyStimulus(1'b1, 1'b0, 16'h0050, 4'b0000, 4'b0000, 1);
    checkOutput("lz_hex",   hex_out,         LZ_HEX);
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'b1000, 4'b0000, 1);
    applyStimulus(1'b1, 1'b0, 16'h0050, 4'b1000, 4'b0000, 1);
    checkOutput("lzdp_hex", hex_out,         32'h40C092C0);

    // Scan: restart from reset and load 4321 on the first edge after release
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 2);
    applyStimulus(1'b1, 1'b1, 16'h4321, 4'b0000, 4'b0000, 1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1);
    checkOutput("scan_hex", hex_out,         32'h99B0A4F9);
    checkOutput("scan0_an", {28'h0, scan_an},  32'h0000000E);
    checkOutput("scan0_sg", {24'h0, scan_seg}, 32'h000000F9);
    tick(4);
    checkOutput("scan1_an", {28'h0, scan_an},  32'h0000000D);
    checkOutput("scan1_sg", {24'h0, scan_seg}, 32'h000000A4);
    tick(4);
    checkOutput("scan2_an", {28'h0, scan_an},  32'h0000000B);
    checkOutput("scan2_sg", {24'h0, scan_seg}, 32'h000000B0);
    tick(4);
    checkOutput("scan3_an", {28'h0, scan_an},  32'h00000007);
    checkOutput("scan3_sg", {24'h0, scan_seg}, 32'h00000099);
    tick(4);
    checkOutput("scanw_an", {28'h0, scan_an},  32'h0000000E);
    checkOutput("scanw_sg", {24'h0, scan_seg}, 32'h000000F9);
    tick(8);
    checkOutput("scan2b_an", {28'h0, scan_an}, 32'h0000000B);

    // Mid-run reset while digit 2 is selected
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1);
    checkOutput("mrst_an",  {28'h0, scan_an},  32'h0000000F);
    checkOutput("mrst_sg",  {24'h0, scan_seg}, 32'h000000FF);
    checkOutput("mrst_hex", hex_out,         32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1);
    checkOutput("mrel_an",  {28'h0, scan_an},  32'h0000000E);
    checkOutput("mrel_hex", hex_out,         ZERO_HEX);
    checkOutput("mrel_sg",  {24'h0, scan_seg}, 32'h000000C0);

    // Blink digit 1: visible edges 1..8, blank 9..16, visible 17..24, blank from 25
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0010, 2);
    applyStimulus(1'b1, 1'b1, 16'h4321, 4'b0000, 4'b0010, 1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0010, 1);
    checkOutput("blk_vis2",  hex_out,        32'h99B0A4F9);
    tick(6);
    checkOutput("blk_vis8",  hex_out,        32'h99B0A4F9);
    tick(1);
    checkOutput("blk_off9",  hex_out,        32'h99B0FFF9);
    tick(7);
    checkOutput("blk_off16", hex_out,        32'h99B0FFF9);
    tick(1);
    checkOutput("blk_vis17", hex_out,        32'h99B0A4F9);
    tick(8);
    checkOutput("blk_off25", hex_out,        32'h99B0FFF9);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1);
    checkOutput("blk_mask0", hex_out,        32'h99B0A4F9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
